column_renderer: RTL and testbench

// Double-buffered column store between the raycaster and the VGA colour pins.

---
 rtl/column_renderer.sv | 140 ++++++++++++++
 tb/tb_column_renderer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/column_renderer.sv
// Double-buffered per-column wall store feeding the VGA colour pins.
// A writer fills the back bank; the front bank is expanded into ceiling/wall/floor pixels.
module column_renderer #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned HORIZON     = 240,
  parameter logic [5:0]  CEIL_COLOR  = 6'b000001,
  parameter logic [5:0]  FLOOR_COLOR = 6'b010101
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pix_stb,
  input  logic       i_col_valid,
  output logic       o_col_ready,
  input  logic [9:0] i_col_x,
  input  logic [8:0] i_col_height,
  input  logic [5:0] i_col_color,
  input  logic       i_col_last,
  input  logic       i_frame_start,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  output logic [1:0] o_red,
  output logic [1:0] o_green,
  output logic [1:0] o_blue,
  output logic       o_swap
);

  localparam logic [9:0] L_HRES    = 10'(H_RES);
  localparam logic [8:0] L_VRES    = 9'(V_RES);
  localparam logic [8:0] L_HORIZON = 9'(HORIZON);
  localparam logic [7:0] L_HALFMAX = 8'(HORIZON);

  // Each entry is {height[8:0], colour[5:0]}; contents are deliberately not reset.
  logic [14:0] r_bank0 [H_RES];
  logic [14:0] r_bank1 [H_RES];

  logic        r_front;
  logic        r_front_valid;
  logic        r_pending;
  logic        r_ready;
  logic        r_swap;

  logic        r_s1_vis;
  logic        r_s1_fv;
  logic [8:0]  r_s1_y;
  logic [14:0] r_s1_data;
  logic [5:0]  r_rgb;

  logic        w_xfer;
  logic        w_x_ok;
  logic        w_swap_now;
  logic [14:0] w_wdata;
  logic [9:0]  w_rd_addr;
  logic [7:0]  w_half_raw;
  logic [7:0]  w_half;
  logic [8:0]  w_top;
  logic [8:0]  w_bot;
  logic [5:0]  w_color;

  assign w_xfer     = i_col_valid & r_ready & i_rst_n;
  assign w_x_ok     = (i_col_x < L_HRES);
  assign w_swap_now = i_frame_start & r_pending;
  assign w_wdata    = {i_col_height, i_col_color};
  assign w_rd_addr  = (i_x < L_HRES) ? i_x : 10'd0;

  // The back bank is whichever one the reader is not using.
  always_ff @(posedge i_clk) begin
    if (w_xfer && w_x_ok) begin
      if (r_front) r_bank0[i_col_x] <= w_wdata;
      else         r_bank1[i_col_x] <= w_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_front       <= 1'b0;
      r_front_valid <= 1'b0;
      r_pending     <= 1'b0;
      r_ready       <= 1'b0;
      r_swap        <= 1'b0;
    end else begin
      r_swap <= w_swap_now;
      if (w_swap_now) begin
        r_front       <= ~r_front;
        r_front_valid <= 1'b1;
        r_pending     <= 1'b0;
        r_ready       <= 1'b1;
      end else if (w_xfer && i_col_last) begin
        r_pending <= 1'b1;
        r_ready   <= 1'b0;
      end else begin
        r_ready <= ~r_pending;
      end
    end
  end

  // Wall spans [HORIZON-half, HORIZON+half); clamping half keeps both bounds in range.
  assign w_half_raw = r_s1_data[14:7];
  assign w_half     = (w_half_raw > L_HALFMAX) ? L_HALFMAX : w_half_raw;
  assign w_top      = L_HORIZON - {1'b0, w_half};
  assign w_bot      = L_HORIZON + {1'b0, w_half};

  always_comb begin
    w_color = 6'd0;
    if (!r_s1_vis) begin
      w_color = 6'd0;
    end else if (!r_s1_fv) begin
      w_color = (r_s1_y < L_HORIZON) ? CEIL_COLOR : FLOOR_COLOR;
    end else if (r_s1_y < w_top) begin
      w_color = CEIL_COLOR;
    end else if (r_s1_y < w_bot) begin
      w_color = r_s1_data[5:0];
    end else begin
      w_color = FLOOR_COLOR;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_vis  <= 1'b0;
      r_s1_fv   <= 1'b0;
      r_s1_y    <= 9'd0;
      r_s1_data <= 15'd0;
      r_rgb     <= 6'd0;
    end else if (i_pix_stb) begin
      r_s1_vis  <= (i_x < L_HRES) && (i_y < L_VRES);
      r_s1_fv   <= r_front_valid;
      r_s1_y    <= i_y;
      r_s1_data <= r_front ? r_bank1[w_rd_addr] : r_bank0[w_rd_addr];
      r_rgb     <= w_color;
    end
  end

  assign o_col_ready = r_ready;
  assign o_swap      = r_swap;
  assign o_red       = r_rgb[5:4];
  assign o_green     = r_rgb[3:2];
  assign o_blue      = r_rgb[1:0];

endmodule

// File: tb/tb_column_renderer.sv
// Directed bench for column_renderer: table-driven pixel checks plus handshake,
// double-buffer and reset sequences with hand-computed expectations.
module tb_column_renderer;

  localparam logic [5:0] CEIL  = 6'b000001;
  localparam logic [5:0] FLOOR = 6'b010101;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_pix_stb = 1'b0;
  logic       i_col_valid = 1'b0;
  logic       o_col_ready;
  logic [9:0] i_col_x = '0;
  logic [8:0] i_col_height = '0;
  logic [5:0] i_col_color = '0;
  logic       i_col_last = 1'b0;
  logic       i_frame_start = 1'b0;
  logic [9:0] i_x = '0;
  logic [8:0] i_y = '0;
  logic [1:0] o_red, o_green, o_blue;
  logic       o_swap;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t tblA[$];
  vec_t tblB[$];

  column_renderer dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_pix_stb(i_pix_stb),
    .i_col_valid(i_col_valid), .o_col_ready(o_col_ready),
    .i_col_x(i_col_x), .i_col_height(i_col_height), .i_col_color(i_col_color),
    .i_col_last(i_col_last), .i_frame_start(i_frame_start),
    .i_x(i_x), .i_y(i_y), .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_swap(o_swap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rgb();
    return {2'b00, o_red, o_green, o_blue};
  endfunction

  // One pixel strobe, then three idle cycles to mimic a 1-in-4 enable.
  task automatic strobe();
    i_pix_stb = 1'b1;
    tick();
    i_pix_stb = 1'b0;
    repeat (3) tick();
  endtask

  task automatic applyStimulus(input logic [9:0] x, input logic [8:0] y);
    i_x = x;
    i_y = y;
    strobe();
    strobe();
  endtask

  task automatic runTable(input vec_t tbl[$]);
    foreach (tbl[k]) begin
      applyStimulus(tbl[k].x, tbl[k].y);
      checkOutput(tbl[k].name, rgb(), {2'b00, tbl[k].exp});
    end
  endtask

  task automatic writeCol(input logic [9:0] x, input logic [8:0] h,
                          input logic [5:0] c, input logic last, input string name);
    bit done = 0;
    i_col_x = x;
    i_col_height = h;
    i_col_color = c;
    i_col_last = last;
    i_col_valid = 1'b1;
    for (int n = 0; n < 16 && !done; n++) begin
      if (o_col_ready) done = 1;
      tick();
    end
    i_col_valid = 1'b0;
    i_col_last = 1'b0;
    if (!done) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s: handshake timeout, ready stayed 0, expected 1", name);
    end
  endtask

  task automatic frameStart();
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
  endtask

  initial begin
    tblA.push_back('{10'd5,   9'd100, CEIL,     "empty_ceil"});
    tblA.push_back('{10'd5,   9'd300, FLOOR,    "empty_floor"});
    tblA.push_back('{10'd700, 9'd10,  6'd0,     "offscreen_x"});
    tblA.push_back('{10'd5,   9'd480, 6'd0,     "offscreen_y"});
    tblA.push_back('{10'd5,   9'd240, FLOOR,    "empty_horizon"});

    tblB.push_back('{10'd10,  9'd189, CEIL,      "x10_y189"});
    tblB.push_back('{10'd10,  9'd190, 6'b110000, "x10_y190"});
    tblB.push_back('{10'd10,  9'd289, 6'b110000, "x10_y289"});
    tblB.push_back('{10'd10,  9'd290, FLOOR,     "x10_y290"});
    tblB.push_back('{10'd0,   9'd239, CEIL,      "h0_y239"});
    tblB.push_back('{10'd0,   9'd240, FLOOR,     "h0_y240"});
    tblB.push_back('{10'd639, 9'd0,   6'b001111, "h511_y0"});
    tblB.push_back('{10'd639, 9'd479, 6'b001111, "h511_y479"});
    tblB.push_back('{10'd639, 9'd480, 6'd0,      "h511_offscreen"});

    // Reset behaviour
    repeat (3) tick();
    checkOutput("reset_ready", {7'd0, o_col_ready}, 8'd0);
    checkOutput("reset_rgb", rgb(), 8'd0);
    checkOutput("reset_swap", {7'd0, o_swap}, 8'd0);
    i_rst_n = 1'b1;
    tick();
    checkOutput("ready_after_reset", {7'd0, o_col_ready}, 8'd1);

    runTable(tblA);

    // First frame with backpressure after the last descriptor
    writeCol(10'd10, 9'd100, 6'b110000, 1'b0, "wr_x10");
    writeCol(10'd0, 9'd0, 6'b111111, 1'b0, "wr_x0");
    writeCol(10'd639, 9'd511, 6'b001111, 1'b1, "wr_x639");
    checkOutput("ready_after_last", {7'd0, o_col_ready}, 8'd0);
    i_col_x = 10'd10; i_col_height = 9'd100; i_col_color = 6'b000011; i_col_valid = 1'b1;
    repeat (3) tick();
    checkOutput("ready_held_low", {7'd0, o_col_ready}, 8'd0);
    i_col_valid = 1'b0;
    frameStart();
    checkOutput("swap_pulse", {7'd0, o_swap}, 8'd1);
    checkOutput("ready_after_swap", {7'd0, o_col_ready}, 8'd1);
    tick();
    checkOutput("swap_one_cycle", {7'd0, o_swap}, 8'd0);

    runTable(tblB);

    // Two-strobe latency and hold between strobes
    i_x = 10'd10; i_y = 9'd100;
    strobe();
    checkOutput("lat_stb1", rgb(), 8'd0);
    i_y = 9'd200;
    strobe();
    checkOutput("lat_stb2", rgb(), {2'b00, CEIL});
    repeat (5) tick();
    checkOutput("lat_hold", rgb(), {2'b00, CEIL});
    strobe();
    checkOutput("lat_stb3", rgb(), 8'b00110000);

    // Double buffer: frame A shown, frame B written but not yet swapped
    writeCol(10'd20, 9'd100, 6'b001100, 1'b1, "wr_frameA");
    frameStart();
    checkOutput("swap_frameA", {7'd0, o_swap}, 8'd1);
    applyStimulus(10'd20, 9'd240);
    checkOutput("frameA_x20", rgb(), 8'b00001100);
    writeCol(10'd640, 9'd100, 6'b111111, 1'b0, "wr_x640_dropped");
    checkOutput("ready_after_x640", {7'd0, o_col_ready}, 8'd1);
    i_col_x = 10'd20; i_col_height = 9'd100; i_col_color = 6'b000011;
    i_col_last = 1'b1; i_col_valid = 1'b1; i_frame_start = 1'b1;
    tick();
    i_col_valid = 1'b0; i_col_last = 1'b0; i_frame_start = 1'b0;
    checkOutput("sameCycle_no_swap", {7'd0, o_swap}, 8'd0);
    checkOutput("sameCycle_ready", {7'd0, o_col_ready}, 8'd0);
    applyStimulus(10'd20, 9'd240);
    checkOutput("frameB_unswapped", rgb(), 8'b00001100);
    frameStart();
    checkOutput("swap_frameB", {7'd0, o_swap}, 8'd1);
    applyStimulus(10'd20, 9'd240);
    checkOutput("frameB_swapped", rgb(), 8'b00000011);

    // Reset in the middle of filling a frame
    for (int i = 0; i < 300; i++)
      writeCol(10'(i), 9'd100, 6'b110000, 1'b0, "wr_partial");
    i_rst_n = 1'b0;
    repeat (2) tick();
    checkOutput("midreset_ready", {7'd0, o_col_ready}, 8'd0);
    i_rst_n = 1'b1;
    frameStart();
    checkOutput("midreset_no_swap", {7'd0, o_swap}, 8'd0);
    checkOutput("midreset_ready_back", {7'd0, o_col_ready}, 8'd1);
    applyStimulus(10'd20, 9'd240);
    checkOutput("midreset_floor", rgb(), {2'b00, FLOOR});
    applyStimulus(10'd20, 9'd100);
    checkOutput("midreset_ceil", rgb(), {2'b00, CEIL});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
